cpu_clk_ctrl: RTL and testbench

//   Run-control stage directly downstream of the board clock divider. Converts the divided

---
 rtl/cpu_clk_ctrl.sv | 115 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// Run-control stage: turns divided slow-clock rises into single-cycle core enables under
// free-run / halt / single-step control. Optional breakpoint halt via CLKCTRL_BREAKPOINT_EN.
module cpu_clk_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_clk_i,
   input  logic             btn_run_i,
   input  logic             btn_step_i,
`ifdef CLKCTRL_BREAKPOINT_EN
   input  logic [31:0]      pc_i,
   input  logic [31:0]      bp_addr_i,
   input  logic             bp_valid_i,
`endif
   output logic             cpu_ce_o,
   output logic             run_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] step_cnt_o
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DbW-1:0]   DbLast = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DbW-1:0]   DbOne  = DbW'(1);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [1:0] {
      StHalt     = 2'b00,
      StRun      = 2'b01,
      StStepWait = 2'b10,
      StBad      = 2'b11
   } state_e;

   state_e           state_q;
   logic             ce_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       slow_q;
   logic [1:0]       sync1_q, sync2_q, stable_q, stable_dly_q;
   logic [DbW-1:0]   db_cnt_q [2];
   logic             tick, run_press, step_press, bp_hit;

   assign tick       = slow_q[1] & ~slow_q[2];
   assign run_press  = stable_q[0] & ~stable_dly_q[0];
   assign step_press = stable_q[1] & ~stable_dly_q[1];

`ifdef CLKCTRL_BREAKPOINT_EN
   assign bp_hit = bp_valid_i && (pc_i == bp_addr_i);
`else
   assign bp_hit = 1'b0;
`endif

   // Bit 0 is the run button, bit 1 the step button.
   always_ff @(posedge clk) begin
      if (rst) begin
         slow_q       <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         db_cnt_q[0]  <= '0;
         db_cnt_q[1]  <= '0;
      end else begin
         slow_q       <= {slow_q[1:0], slow_clk_i};
         sync1_q      <= {btn_step_i, btn_run_i};
         sync2_q      <= sync1_q;
         stable_dly_q <= stable_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbLast) begin
               stable_q[i] <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DbOne;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StHalt;
         ce_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ce_q <= 1'b0;
         if (ce_q) cnt_q <= cnt_q + CntOne;
         case (state_q)
            StHalt: begin
               if (run_press)       state_q <= StRun;
               else if (step_press) state_q <= StStepWait;
            end
            StRun: begin
               if (tick && !bp_hit) ce_q <= 1'b1;
               if (run_press)            state_q <= StHalt;
               else if (tick && bp_hit)  state_q <= StHalt;
            end
            StStepWait: begin
               // Steps are never blocked by a breakpoint so it can be stepped over.
               if (tick) ce_q <= 1'b1;
               if (run_press) state_q <= StRun;
               else if (tick) state_q <= StHalt;
            end
            default: state_q <= StHalt;
         endcase
      end
   end

   assign cpu_ce_o   = ce_q;
   assign run_o      = (state_q == StRun);
   assign state_o    = state_q;
   assign step_cnt_o = cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a ce/count scoreboard; a narrow-counter twin checks wrap.
module tb_cpu_clk_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        slow_clk_i = 1'b0;
   logic        btn_run_i = 1'b0;
   logic        btn_step_i = 1'b0;
   logic        cpu_ce_o, run_o;
   logic [1:0]  state_o;
   logic [15:0] step_cnt_o;
   logic        ce_n, run_n;
   logic [1:0]  state_n;
   logic [3:0]  cnt_n;
`ifdef CLKCTRL_BREAKPOINT_EN
   logic [31:0] pc_i = '0;
   logic [31:0] bp_addr_i = '0;
   logic        bp_valid_i = 1'b0;
`endif

   always #5 clk = ~clk;

   cpu_clk_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .slow_clk_i(slow_clk_i), .btn_run_i(btn_run_i),
      .btn_step_i(btn_step_i),
`ifdef CLKCTRL_BREAKPOINT_EN
      .pc_i(pc_i), .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i),
`endif
      .cpu_ce_o(cpu_ce_o), .run_o(run_o), .state_o(state_o), .step_cnt_o(step_cnt_o)
   );

   cpu_clk_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut_n (
      .clk(clk), .rst(rst), .slow_clk_i(slow_clk_i), .btn_run_i(btn_run_i),
      .btn_step_i(btn_step_i),
`ifdef CLKCTRL_BREAKPOINT_EN
      .pc_i(pc_i), .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i),
`endif
      .cpu_ce_o(ce_n), .run_o(run_n), .state_o(state_n), .step_cnt_o(cnt_n)
   );

   typedef struct {
      logic [19:0] mask;
      logic [31:0] cnt;
      logic [1:0]  st;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_cnt = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic chk_state(input string tag, input logic [1:0] want);
      chk(tag, {30'd0, state_o}, {30'd0, want});
      chk({tag, "_run"}, {31'd0, run_o}, {31'd0, want == 2'b01});
   endtask

   // One slow-clock period (10 high, 10 low); ce must appear only after the 3rd edge.
   task automatic slow_cycle(input string tag, input bit exp_ce, input logic [1:0] st_after);
      exp_t        e;
      logic [19:0] mask = '0;
      if (exp_ce) exp_cnt++;
      e.mask = exp_ce ? 20'h00004 : 20'h00000;
      e.cnt  = exp_cnt;
      e.st   = st_after;
      sb.push_back(e);
      slow_clk_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) slow_clk_i = 1'b0;
         step();
         mask[i] = cpu_ce_o;
      end
      e = sb.pop_front();
      chk({tag, "_ce"}, {12'd0, mask}, {12'd0, e.mask});
      chk({tag, "_cnt"}, {16'd0, step_cnt_o}, e.cnt);
      chk({tag, "_cntn"}, {28'd0, cnt_n}, e.cnt & 32'hF);
      chk({tag, "_st"}, {30'd0, state_o}, {30'd0, e.st});
   endtask

   task automatic press(input bit which_step, input int n);
      if (which_step) btn_step_i = 1'b1;
      else            btn_run_i = 1'b1;
      repeat (n) step();
      btn_run_i  = 1'b0;
      btn_step_i = 1'b0;
      repeat (10) step();
   endtask

   initial begin
      // 1: reset, then slow clock alone does nothing
      repeat (3) step();
      chk("rst_ce", {31'd0, cpu_ce_o}, 32'd0);
      chk("rst_cnt", {16'd0, step_cnt_o}, 32'd0);
      chk_state("rst_st", 2'b00);
      rst = 1'b0;
      slow_cycle("idle0", 1'b0, 2'b00);
      slow_cycle("idle1", 1'b0, 2'b00);

      // 2: free run
      press(1'b0, 6);
      chk_state("run_st", 2'b01);
      for (int i = 0; i < 5; i++) slow_cycle("run", 1'b1, 2'b01);
      chk("run5_cnt", {16'd0, step_cnt_o}, 32'd5);
      press(1'b1, 6);
      chk_state("run_stepign", 2'b01);
      press(1'b0, 6);
      chk_state("halt_st", 2'b00);
      slow_cycle("halt_tick", 1'b0, 2'b00);

      // 3: single step
      press(1'b1, 6);
      chk_state("sw_st", 2'b10);
      slow_cycle("step", 1'b1, 2'b00);
      slow_cycle("step2", 1'b0, 2'b00);

      // 4: debounce
      for (int i = 0; i < 20; i++) begin
         btn_run_i = i[0] ? 1'b0 : 1'b1;
         step();
      end
      btn_run_i = 1'b0;
      repeat (10) step();
      chk_state("bounce", 2'b00);
      press(1'b0, 3);
      chk_state("short3", 2'b00);
      press(1'b0, 4);
      chk_state("len4", 2'b01);

      // 5: wrap (narrow twin wraps at 16) and reset mid-run
      for (int i = 0; i < 12; i++) slow_cycle("wrap", 1'b1, 2'b01);
      chk("wrap_n", {28'd0, cnt_n}, 32'd2);
      rst = 1'b1;
      step();
      chk_state("mrst_st", 2'b00);
      chk("mrst_cnt", {16'd0, step_cnt_o}, 32'd0);
      rst = 1'b0;
      exp_cnt = 0;
      slow_cycle("post_rst", 1'b0, 2'b00);

`ifdef CLKCTRL_BREAKPOINT_EN
      // 6: breakpoint halts the run, a step moves past it
      bp_addr_i  = 32'h00400010;
      bp_valid_i = 1'b1;
      pc_i       = 32'h00400000;
      press(1'b0, 6);
      slow_cycle("bp_pre", 1'b1, 2'b01);
      pc_i = 32'h00400010;
      slow_cycle("bp_hit", 1'b0, 2'b00);
      press(1'b1, 6);
      chk_state("bp_sw", 2'b10);
      slow_cycle("bp_step", 1'b1, 2'b00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
